// File: rtl/adder_result_serializer.sv
// Captures five adder results on a load strobe and streams them as a 7-beat
// valid/ready frame: header, v, w, x, y, z, checksum.
module adder_result_serializer #(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] HEADER = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] v,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [DATA_W-1:0] z,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              drop_err,
    input  logic              clr_err
);

    localparam int          NUM_RES  = 5;
    localparam logic [2:0]  LAST_IDX = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              drop_err_q, drop_err_d;
    logic              capture;
    logic [DATA_W-1:0] sum_all;

    logic [DATA_W-1:0] in_bytes [NUM_RES];
    logic [DATA_W-1:0] shadow_q [NUM_RES];

    assign in_bytes[0] = v;
    assign in_bytes[1] = w;
    assign in_bytes[2] = x;
    assign in_bytes[3] = y;
    assign in_bytes[4] = z;

    // Unsigned sum truncated to the byte width; the carry is intentionally lost.
    assign sum_all = v + w + x + y + z;

    generate
        for (genvar gi = 0; gi < NUM_RES; gi++) begin : g_shadow
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_q[gi] <= '0;
                end else if (capture) begin
                    shadow_q[gi] <= in_bytes[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            csum_q     <= '0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            drop_err_q <= drop_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        capture    = 1'b0;
        drop_err_d = drop_err_q;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    capture = 1'b1;
                    csum_d  = sum_all;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A load during a frame (even on its final beat) is dropped; set beats clear.
        if (load && (state_q == S_SEND)) begin
            drop_err_d = 1'b1;
        end else if (clr_err) begin
            drop_err_d = 1'b0;
        end
    end

    always_comb begin
        out_valid = (state_q == S_SEND);
        busy      = (state_q == S_SEND);
        out_last  = (state_q == S_SEND) && (idx_q == LAST_IDX);
        drop_err  = drop_err_q;
        out_data  = '0;
        if (state_q == S_SEND) begin
            case (idx_q)
                3'd0:    out_data = HEADER;
                3'd1:    out_data = shadow_q[0];
                3'd2:    out_data = shadow_q[1];
                3'd3:    out_data = shadow_q[2];
                3'd4:    out_data = shadow_q[3];
                3'd5:    out_data = shadow_q[4];
                3'd6:    out_data = csum_q;
                default: out_data = '0;
            endcase
        end
    end

endmodule
